cmd_arbiter: RTL and testbench

Sequencer and round-robin arbiter sitting in front of `cmd_controller` on the SD host CMD path. It lets two requesters share the single command controller: the data-transfer controller (port 0, e.g. CMD17/CMD12) and the host register interface (port 1). It issues one command at a time, retries on response timeout and returns the response and status to the requester that owns the command. It enforces the SD minimum inter-command gap between commands.

---
 rtl/cmd_arbiter_pkg.sv | 24 ++
 rtl/cmd_rr_arbiter.sv | 24 ++
 rtl/counter.sv | 34 +++
 rtl/cmd_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_cmd_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_arbiter_pkg.sv
// Shared definitions for the SD host CMD path arbiter.
// Contents:
//   cmdState_t          sequencer state encoding
//   STATUS_*_BIT        bit positions inside the 2-bit status word
//   CMD_GO_IDLE         index of CMD0, the only command sent without a response timeout
//   DEFAULT_GAP_CYCLES  default minimum idle clocks between commands (Ncc)
package definitionsCMDcontroller;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_REPORT = 3'd3,
        ST_GAP    = 3'd4
    } cmdState_t;

    localparam int STATUS_FAIL_BIT  = 0;
    localparam int STATUS_RETRY_BIT = 1;

    localparam logic [5:0] CMD_GO_IDLE = 6'd0;

    localparam int DEFAULT_GAP_CYCLES = 8;

endpackage

// File: rtl/cmd_rr_arbiter.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   valid_i     request valids, bit N = port N
//   last_i      port that owned the most recent completed command
//   grant_o     some port is requesting
//   grantIdx_o  winning port (meaningful only while grant_o is high)
module cmd_rr_arbiter (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       grantIdx_o
);

    // The port that did not go last gets first pick; the last owner only wins
    // when it is the sole requester.
    always_comb begin
        grant_o    = |valid_i;
        grantIdx_o = last_i;
        if (valid_i[~last_i]) begin
            grantIdx_o = ~last_i;
        end
    end

endmodule

// File: rtl/counter.sv
// Generic free-running up counter with synchronous clear.
// Ports:
//   clock    clock
//   reset    asynchronous active-low reset
//   clear_i  forces the count back to zero on the next edge (wins over enable_i)
//   enable_i advances the count by one
//   count_o  current count
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count register: clear has priority so the owner can restart the count
    // in the same cycle it would otherwise have advanced.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cmd_arbiter.sv
// Sequencer and round-robin arbiter in front of cmd_controller. Two requesters
// (port 0 = data-transfer controller, port 1 = host register interface) share
// the controller; one command runs at a time, timeouts are retried up to
// MAX_RETRY times, and GAP_CYCLES idle clocks separate consecutive issues.
// Ports:
//   clock, reset                     clock, asynchronous active-low reset
//   reqN_valid/index/arg             command request from port N
//   reqN_ready                       one-cycle accept pulse to port N
//   reqN_done                        one-cycle completion pulse to port N
//   status                           bit0 final timeout, bit1 retry occurred
//   response                         last captured controller response
//   ctrl_idle/done/timeout/response  handshake from cmd_controller
//   ctrl_new_command                 one-cycle start pulse to cmd_controller
//   ctrl_index/arg                   latched command for cmd_controller
//   ctrl_timeout_enable              low only for CMD0
module cmd_arbiter
    import definitionsCMDcontroller::*;
#(
    parameter int MAX_RETRY  = 2,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [5:0]   req0_index,
    input  logic [31:0]  req0_arg,
    input  logic         req1_valid,
    input  logic [5:0]   req1_index,
    input  logic [31:0]  req1_arg,
    output logic         req0_ready,
    output logic         req1_ready,
    output logic         req0_done,
    output logic         req1_done,
    output logic [1:0]   status,
    output logic [135:0] response,
    input  logic         ctrl_idle,
    input  logic         ctrl_done,
    input  logic         ctrl_timeout,
    input  logic [135:0] ctrl_response,
    output logic         ctrl_new_command,
    output logic [5:0]   ctrl_index,
    output logic [31:0]  ctrl_arg,
    output logic         ctrl_timeout_enable
);

    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);
    localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

    cmdState_t      state_q, state_d;
    logic           last_q, last_d;
    logic           owner_q, owner_d;
    logic [7:0]     retryCnt_q, retryCnt_d;
    logic           retryFlag_q, retryFlag_d;
    logic [5:0]     index_q, index_d;
    logic [31:0]    arg_q, arg_d;
    logic           toEnable_q, toEnable_d;
    logic [1:0]     status_q, status_d;
    logic [135:0]   response_q, response_d;
    logic           newCmd_q, newCmd_d;
    logic           ready0_q, ready0_d;
    logic           ready1_q, ready1_d;
    logic           done0_q, done0_d;
    logic           done1_q, done1_d;

    logic           grantValid;
    logic           grantIdx;
    logic [7:0]     gapCount;
    logic           gapDone;
    logic [5:0]     selIndex;

    cmd_rr_arbiter rrArbiter (
        .valid_i    ({req1_valid, req0_valid}),
        .last_i     (last_q),
        .grant_o    (grantValid),
        .grantIdx_o (grantIdx)
    );

    // The gap counter restarts on every entry to GAP and runs while there.
    counter #(
        .WIDTH (8)
    ) gapCounter (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (state_q != ST_GAP),
        .enable_i (1'b1),
        .count_o  (gapCount)
    );

    assign gapDone  = (gapCount == GAP_LAST);
    assign selIndex = grantIdx ? req1_index : req0_index;

    // Next-state and registered-output logic. The start pulse is registered,
    // so it is armed on the edge that enters (or stays in) ISSUE using the
    // ctrl_idle seen at that edge, and ISSUE is left on the edge that ends the
    // pulse. Status is only committed on the final exit from WAIT so it stays
    // stable across retries of the same command.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        retryCnt_d  = retryCnt_q;
        retryFlag_d = retryFlag_q;
        index_d     = index_q;
        arg_d       = arg_q;
        toEnable_d  = toEnable_q;
        status_d    = status_q;
        response_d  = response_q;
        newCmd_d    = 1'b0;
        ready0_d    = 1'b0;
        ready1_d    = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grantValid) begin
                    owner_d     = grantIdx;
                    index_d     = selIndex;
                    arg_d       = grantIdx ? req1_arg : req0_arg;
                    toEnable_d  = (selIndex != CMD_GO_IDLE);
                    retryCnt_d  = '0;
                    retryFlag_d = 1'b0;
                    ready0_d    = ~grantIdx;
                    ready1_d    = grantIdx;
                    newCmd_d    = ctrl_idle;
                    state_d     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (newCmd_q) begin
                    state_d = ST_WAIT;
                end else begin
                    newCmd_d = ctrl_idle;
                end
            end

            ST_WAIT: begin
                if (ctrl_done) begin
                    response_d                 = ctrl_response;
                    status_d[STATUS_FAIL_BIT]  = 1'b0;
                    status_d[STATUS_RETRY_BIT] = (retryCnt_q != '0);
                    done0_d                    = ~owner_q;
                    done1_d                    = owner_q;
                    last_d                     = owner_q;
                    state_d                    = ST_REPORT;
                end else if (ctrl_timeout) begin
                    if (retryCnt_q < RETRY_LIMIT) begin
                        retryCnt_d  = retryCnt_q + 1'b1;
                        retryFlag_d = 1'b1;
                        state_d     = ST_GAP;
                    end else begin
                        status_d[STATUS_FAIL_BIT]  = 1'b1;
                        status_d[STATUS_RETRY_BIT] = (retryCnt_q != '0);
                        done0_d                    = ~owner_q;
                        done1_d                    = owner_q;
                        last_d                     = owner_q;
                        state_d                    = ST_REPORT;
                    end
                end
            end

            ST_REPORT: begin
                state_d = ST_GAP;
            end

            ST_GAP: begin
                if (gapDone) begin
                    if (retryFlag_q) begin
                        retryFlag_d = 1'b0;
                        newCmd_d    = ctrl_idle;
                        state_d     = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight command.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            retryCnt_q  <= '0;
            retryFlag_q <= 1'b0;
            index_q     <= '0;
            arg_q       <= '0;
            toEnable_q  <= 1'b1;
            status_q    <= '0;
            response_q  <= '0;
            newCmd_q    <= 1'b0;
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            retryCnt_q  <= retryCnt_d;
            retryFlag_q <= retryFlag_d;
            index_q     <= index_d;
            arg_q       <= arg_d;
            toEnable_q  <= toEnable_d;
            status_q    <= status_d;
            response_q  <= response_d;
            newCmd_q    <= newCmd_d;
            ready0_q    <= ready0_d;
            ready1_q    <= ready1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
        end
    end

    assign req0_ready          = ready0_q;
    assign req1_ready          = ready1_q;
    assign req0_done           = done0_q;
    assign req1_done           = done1_q;
    assign status              = status_q;
    assign response            = response_q;
    assign ctrl_new_command    = newCmd_q;
    assign ctrl_index          = index_q;
    assign ctrl_arg            = arg_q;
    assign ctrl_timeout_enable = toEnable_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Testbench for cmd_arbiter: a scripted cmd_controller model answers each
// start pulse, a monitor pops the scoreboard on every done pulse, and the
// main sequence checks latencies, retry behaviour, arbitration and reset.
module tb_cmd_arbiter;

    localparam int GAP  = 8;
    localparam int MAXR = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [5:0]   req0_index, req1_index;
    logic [31:0]  req0_arg, req1_arg;
    logic         req0_ready, req1_ready, req0_done, req1_done;
    logic [1:0]   status;
    logic [135:0] response;
    logic         ctrl_idle, ctrl_done, ctrl_timeout;
    logic [135:0] ctrl_response;
    logic         ctrl_new_command;
    logic [5:0]   ctrl_index;
    logic [31:0]  ctrl_arg;
    logic         ctrl_timeout_enable;

    cmd_arbiter #(
        .MAX_RETRY  (MAXR),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .req0_valid          (req0_valid),
        .req0_index          (req0_index),
        .req0_arg            (req0_arg),
        .req1_valid          (req1_valid),
        .req1_index          (req1_index),
        .req1_arg            (req1_arg),
        .req0_ready          (req0_ready),
        .req1_ready          (req1_ready),
        .req0_done           (req0_done),
        .req1_done           (req1_done),
        .status              (status),
        .response            (response),
        .ctrl_idle           (ctrl_idle),
        .ctrl_done           (ctrl_done),
        .ctrl_timeout        (ctrl_timeout),
        .ctrl_response       (ctrl_response),
        .ctrl_new_command    (ctrl_new_command),
        .ctrl_index          (ctrl_index),
        .ctrl_arg            (ctrl_arg),
        .ctrl_timeout_enable (ctrl_timeout_enable)
    );

    always #5 clock = ~clock;

    // Edge counter; sampled values of it identify the edge just passed.
    int cycleCnt = 0;
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    typedef struct {
        bit           port;
        logic [5:0]   index;
        logic [31:0]  arg;
        logic [1:0]   status;
        logic [135:0] resp;
    } expect_t;

    // action: 0 done, 1 timeout, 2 done+timeout together, 3 never answer
    typedef struct {
        int           action;
        logic [135:0] resp;
    } ctrlStep_t;

    expect_t   sb[$];
    ctrlStep_t script[$];
    expect_t   monE;
    ctrlStep_t step;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount   = 0;
    int readyCount  = 0;
    int pulseCount  = 0;
    int lastDoneCycle, lastReadyCycle, lastPulseCycle, lastStrobeEdge;
    bit lastReadyPort;
    bit holdMode    = 1'b0;
    bit prevTimeout = 1'b0;
    logic [135:0] expResp;

    task automatic checkOutput(input string tag, input logic [135:0] observed,
                               input logic [135:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [135:0] junk();
        return {$urandom(), $urandom(), $urandom(), $urandom(), 8'hA5};
    endfunction

    task automatic pushExpect(input bit port, input logic [5:0] idx, input logic [31:0] arg,
                              input logic [1:0] st, input logic [135:0] resp);
        expect_t e;
        e.port = port; e.index = idx; e.arg = arg; e.status = st; e.resp = resp;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input bit port, input logic [5:0] idx, input logic [31:0] arg,
                                 input logic [1:0] st, input logic [135:0] resp);
        pushExpect(port, idx, arg, st, resp);
        if (port) begin
            req1_index = idx; req1_arg = arg; req1_valid = 1'b1;
        end else begin
            req0_index = idx; req0_arg = arg; req0_valid = 1'b1;
        end
    endtask

    // which: 0 = done count, 1 = ready count, 2 = pulse count
    task automatic waitFor(input string tag, input int which, input int target);
        int n = 0;
        int val;
        val = (which == 0) ? doneCount : (which == 1) ? readyCount : pulseCount;
        while (val < target && n < 400) begin
            @(posedge clock); #1;
            n++;
            val = (which == 0) ? doneCount : (which == 1) ? readyCount : pulseCount;
        end
        if (val < target) checkOutput(tag, val, target);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".req0_ready"}, req0_ready, 0);
        checkOutput({tag, ".req1_ready"}, req1_ready, 0);
        checkOutput({tag, ".req0_done"}, req0_done, 0);
        checkOutput({tag, ".req1_done"}, req1_done, 0);
        checkOutput({tag, ".newCommand"}, ctrl_new_command, 0);
        checkOutput({tag, ".ctrlIndex"}, ctrl_index, 0);
        checkOutput({tag, ".ctrlArg"}, ctrl_arg, 0);
        checkOutput({tag, ".status"}, status, 0);
        checkOutput({tag, ".response"}, response, 0);
        checkOutput({tag, ".timeoutEnable"}, ctrl_timeout_enable, 1);
    endtask

    // Requester-side monitor: ready/done pulses, scoreboard pops.
    always begin
        @(negedge clock);
        if (reset) begin
            if (req0_ready || req1_ready) begin
                readyCount++;
                lastReadyCycle = cycleCnt;
                lastReadyPort  = req1_ready;
                if (!holdMode) begin
                    if (req0_ready) req0_valid = 1'b0;
                    if (req1_ready) req1_valid = 1'b0;
                end
            end
            if (req0_done || req1_done) begin
                doneCount++;
                lastDoneCycle = cycleCnt;
                prevTimeout   = 1'b0;
                if (sb.size() == 0) begin
                    checkOutput("unexpectedDone", {req1_done, req0_done}, 0);
                end else begin
                    monE = sb.pop_front();
                    checkOutput("donePort", {req1_done, req0_done}, monE.port ? 2'b10 : 2'b01);
                    checkOutput("status", status, monE.status);
                    checkOutput("response", response, monE.resp);
                    checkOutput("doneLatency", cycleCnt, lastStrobeEdge);
                end
            end
        end
    end

    // cmd_controller model: answers each start pulse per the script.
    always begin
        @(negedge clock);
        if (reset && ctrl_new_command) begin
            pulseCount++;
            lastPulseCycle = cycleCnt;
            if (prevTimeout) checkOutput("retryLatency", cycleCnt, lastStrobeEdge + GAP);
            if (sb.size() != 0) begin
                checkOutput("ctrlIndex", ctrl_index, sb[0].index);
                checkOutput("ctrlArg", ctrl_arg, sb[0].arg);
                checkOutput("timeoutEnable", ctrl_timeout_enable, (sb[0].index != 6'd0));
            end
            if (script.size() != 0) step = script.pop_front();
            else begin step.action = 0; step.resp = junk(); end
            if (step.action != 3) begin
                repeat (2) @(negedge clock);
                ctrl_done      = (step.action == 0) || (step.action == 2);
                ctrl_timeout   = (step.action == 1) || (step.action == 2);
                ctrl_response  = (step.action == 1) ? junk() : step.resp;
                lastStrobeEdge = cycleCnt + 1;
                prevTimeout    = (step.action == 1);
                @(negedge clock);
                ctrl_done     = 1'b0;
                ctrl_timeout  = 1'b0;
                ctrl_response = junk();
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [135:0] r1, rA, rB, rC, rD, rE, rF, rG, rH;
        int driveCycle, pulseBase, doneBase, readyBase, prevDone, idleCycle;

        r1 = 136'h00112233445566778899AABBCC3BA692AF;
        rA = 136'h0A00000000000000000000000000000001;
        rB = 136'h0B00000000000000000000000000000002;
        rC = 136'h0C00000000000000000000000000000003;
        rD = 136'h0D00000000000000000000000000000004;
        rE = 136'h0E0000000000000000000000000000CAFE;
        rF = 136'h0F0000000000000000000000000000BEEF;
        rG = 136'h1100000000000000000000000000001234;
        rH = 136'h2200000000000000000000000000005678;

        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_index = '0; req1_index = '0; req0_arg = '0; req1_arg = '0;
        ctrl_idle = 1'b1; ctrl_done = 1'b0; ctrl_timeout = 1'b0;
        ctrl_response = junk();
        expResp = '0;

        repeat (3) @(posedge clock); #1;
        checkResetOutputs("reset");
        reset = 1'b1;
        @(posedge clock); #1;

        // Single request on port 1
        script.push_back('{0, r1});
        driveCycle = cycleCnt;
        pulseBase  = pulseCount;
        applyStimulus(1'b1, 6'd12, 32'hFA74CD23, 2'b00, r1);
        expResp = r1;
        waitFor("t1Done", 0, 1);
        checkOutput("acceptLatency", lastReadyCycle, driveCycle + 1);
        checkOutput("issueLatency", lastPulseCycle, lastReadyCycle);
        checkOutput("t1Pulses", pulseCount - pulseBase, 1);
        repeat (GAP + 3) @(posedge clock); #1;

        // Both ports held: grants alternate 0,1,0,1
        holdMode = 1'b1;
        script.push_back('{0, rA}); script.push_back('{0, rB});
        script.push_back('{0, rC}); script.push_back('{0, rD});
        applyStimulus(1'b0, 6'd17, 32'h0000_1000, 2'b00, rA);
        applyStimulus(1'b1, 6'd13, 32'h0001_0000, 2'b00, rB);
        pushExpect(1'b0, 6'd17, 32'h0000_1000, 2'b00, rC);
        pushExpect(1'b1, 6'd13, 32'h0001_0000, 2'b00, rD);
        doneBase  = doneCount;
        readyBase = readyCount;
        prevDone  = 0;
        for (int i = 0; i < 4; i++) begin
            waitFor("tieReady", 1, readyBase + i + 1);
            checkOutput("grantPort", lastReadyPort, i % 2);
            if (i > 0) checkOutput("gapToReady", lastReadyCycle - prevDone, GAP + 2);
            waitFor("tieDone", 0, doneBase + i + 1);
            prevDone = lastDoneCycle;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        holdMode = 1'b0;
        expResp = rD;
        repeat (GAP + 3) @(posedge clock); #1;

        // Two timeouts then success
        script.push_back('{1, '0}); script.push_back('{1, '0}); script.push_back('{0, rE});
        pulseBase = pulseCount;
        applyStimulus(1'b0, 6'd17, 32'h0000_2000, 2'b10, rE);
        expResp = rE;
        waitFor("t3Done", 0, doneBase + 5);
        checkOutput("t3Pulses", pulseCount - pulseBase, 3);
        repeat (GAP + 3) @(posedge clock); #1;

        // Three timeouts: final failure, response unchanged
        script.push_back('{1, '0}); script.push_back('{1, '0}); script.push_back('{1, '0});
        pulseBase = pulseCount;
        applyStimulus(1'b1, 6'd55, 32'h1357_9BDF, 2'b11, expResp);
        waitFor("t4Done", 0, doneBase + 6);
        checkOutput("t4Pulses", pulseCount - pulseBase, 3);
        repeat (GAP + 3) @(posedge clock); #1;

        // Controller busy during ISSUE, CMD0, done and timeout together
        ctrl_idle = 1'b0;
        script.push_back('{2, rF});
        pulseBase = pulseCount;
        applyStimulus(1'b0, 6'd0, 32'h0000_0000, 2'b00, rF);
        repeat (6) @(posedge clock); #1;
        checkOutput("noPulseWhileBusy", pulseCount - pulseBase, 0);
        checkOutput("cmd0TimeoutEnable", ctrl_timeout_enable, 0);
        ctrl_idle = 1'b1;
        idleCycle = cycleCnt;
        waitFor("t5Pulse", 2, pulseBase + 1);
        checkOutput("pulseAfterIdle", lastPulseCycle, idleCycle + 1);
        expResp = rF;
        waitFor("t5Done", 0, doneBase + 7);
        checkOutput("t5Pulses", pulseCount - pulseBase, 1);
        repeat (GAP + 3) @(posedge clock); #1;

        // Reset while waiting for a response
        script.push_back('{3, '0});
        pulseBase = pulseCount;
        applyStimulus(1'b1, 6'd8, 32'h0000_01AA, 2'b00, '0);
        waitFor("t6Pulse", 2, pulseBase + 1);
        repeat (2) @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checkResetOutputs("midReset");
        sb.delete();
        prevTimeout = 1'b0;
        expResp = '0;
        doneBase = doneCount;
        repeat (2) @(posedge clock); #1;
        checkOutput("noDoneInReset", doneCount - doneBase, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        script.push_back('{0, rG}); script.push_back('{0, rH});
        applyStimulus(1'b0, 6'd17, 32'h0000_3000, 2'b00, rG);
        applyStimulus(1'b1, 6'd9, 32'h0000_4000, 2'b00, rH);
        waitFor("t6Done", 0, doneBase + 2);
        checkOutput("t6Drained", sb.size(), 0);

        repeat (4) @(posedge clock); #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
